// File: rtl/viral_idx_dispatcher_if.sv
// Sorter/fetcher-side bundle for viral_idx_dispatcher; slave = dispatcher, master = sorter + lanes.
interface viral_idx_dispatcher_if #(
  parameter int COMPRESSION_FACTOR = 16,
  parameter int INDEX_LENGTH       = 16,
  parameter int NUM_LANES          = 2
);
  localparam int SW = COMPRESSION_FACTOR * INDEX_LENGTH;

  // i_idxs_valid is a one-cycle pulse per set and is not held on back-pressure:
  // a set offered while o_idxs_ready is low and nothing dispatches that cycle is dropped.
  // o_lane_start / i_lane_done are single-cycle pulses per lane; o_lane_idxs holds until the next start.
  logic                 i_idxs_valid;
  logic [SW-1:0]        i_idxs;
  logic                 o_idxs_ready;
  logic                 o_overflow;
  logic [NUM_LANES-1:0] o_lane_start;
  logic [SW-1:0]        o_lane_idxs;
  logic [NUM_LANES-1:0] i_lane_done;
  logic [NUM_LANES-1:0] o_lane_busy;
  logic                 o_idle;

  modport slave (
    input  i_idxs_valid, i_idxs, i_lane_done,
    output o_idxs_ready, o_overflow, o_lane_start, o_lane_idxs, o_lane_busy, o_idle
  );

  modport master (
    output i_idxs_valid, i_idxs, i_lane_done,
    input  o_idxs_ready, o_overflow, o_lane_start, o_lane_idxs, o_lane_busy, o_idle
  );
endinterface

// File: rtl/viral_idx_dispatcher.sv
// Index-set FIFO feeding NUM_LANES fetcher lanes round-robin.
// Optional VIRAL_DISPATCH_STATS_EN adds saturating dispatch/drop counters.
module viral_idx_dispatcher #(
  parameter int COMPRESSION_FACTOR = 16,
  parameter int INDEX_LENGTH       = 16,
  parameter int DEPTH              = 4,
  parameter int NUM_LANES          = 2
) (
  input  logic clk,
  input  logic rstn,
  viral_idx_dispatcher_if.slave bus
`ifdef VIRAL_DISPATCH_STATS_EN
  ,
  output logic [31:0] o_dispatch_cnt,
  output logic [15:0] o_drop_cnt
`endif
);
  localparam int SW = COMPRESSION_FACTOR * INDEX_LENGTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [SW-1:0]        mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_nxt;
  logic [LW-1:0]        rr_ptr, sel_lane, rr_nxt;
  logic                 found;
  logic [NUM_LANES-1:0] lane_busy, lane_start, sel_onehot, busy_nxt;
  logic [SW-1:0]        lane_idxs;
  logic                 idxs_ready, overflow;
  logic                 push, pop, drop;

  // First lane with registered busy==0, scanning upward from rr_ptr with wrap.
  always_comb begin
    int j;
    found    = 1'b0;
    sel_lane = rr_ptr;
    j        = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_LANES) j = j - NUM_LANES;
      if (!found && !lane_busy[j]) begin
        found    = 1'b1;
        sel_lane = LW'(j);
      end
    end
  end

  assign rr_nxt     = (int'(sel_lane) == NUM_LANES - 1) ? '0 : sel_lane + LW'(1);
  assign sel_onehot = NUM_LANES'(1) << sel_lane;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  assign pop       = (count != '0) && found;
  assign push      = bus.i_idxs_valid && ((count != DEPTH_C) || pop);
  assign drop      = bus.i_idxs_valid && !push;
  assign count_nxt = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  assign busy_nxt  = (lane_busy & ~bus.i_lane_done) | (pop ? sel_onehot : '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.i_idxs;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      lane_busy  <= '0;
      lane_start <= '0;
      lane_idxs  <= '0;
      idxs_ready <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      count      <= count_nxt;
      lane_busy  <= busy_nxt;
      lane_start <= pop ? sel_onehot : '0;
      idxs_ready <= (count_nxt < DEPTH_C);
      if (pop) begin
        lane_idxs <= mem[rd_ptr];
        rr_ptr    <= rr_nxt;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign bus.o_idxs_ready = idxs_ready;
  assign bus.o_overflow   = overflow;
  assign bus.o_lane_start = lane_start;
  assign bus.o_lane_idxs  = lane_idxs;
  assign bus.o_lane_busy  = lane_busy;
  assign bus.o_idle       = (count == '0) && (lane_busy == '0) && (lane_start == '0);

`ifdef VIRAL_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_dispatch_cnt <= '0;
      o_drop_cnt     <= '0;
    end else begin
      if (pop  && (o_dispatch_cnt != '1)) o_dispatch_cnt <= o_dispatch_cnt + 32'd1;
      if (drop && (o_drop_cnt     != '1)) o_drop_cnt     <= o_drop_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built; o_overflow alone reports drops.
`endif

endmodule
